// File: rtl/video_median_processor_pkg.sv
// Shared constants and helpers for the luma median pipeline.
// Stage latencies, luma weights and 3-input sort primitives.
package video_median_processor_pkg;

  localparam int DW      = 8;
  localparam int ACC_W   = 18;
  localparam int COEF_R  = 77;
  localparam int COEF_G  = 150;
  localparam int COEF_B  = 29;
  localparam int Y_SHIFT = 8;

  localparam int LAT_A     = 3;
  localparam int LAT_B     = 2;
  localparam int LAT_C     = 3;
  localparam int LAT_TOTAL = 8;

  typedef logic [DW-1:0] pix_t;

  typedef struct packed {
    pix_t mx;
    pix_t md;
    pix_t mn;
  } trio_t;

  function automatic pix_t max2(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(pix_t a, pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max3(pix_t a, pix_t b, pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(pix_t a, pix_t b, pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  function automatic trio_t sort3(pix_t a, pix_t b, pix_t c);
    trio_t t;
    t.mx = max3(a, b, c);
    t.mn = min3(a, b, c);
    t.md = med3(a, b, c);
    return t;
  endfunction

endpackage

// File: rtl/video_median_processor_matrix_3x3_gen.sv
// 3x3 luma window builder: two line buffers, column shifters,
// line counter and top-edge padding masks.
module video_median_processor_matrix_3x3_gen
  import video_median_processor_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync_i,
  input  logic                     href_i,
  input  logic                     clken_i,
  input  logic [DW-1:0]            y_i,
  output logic [2:0][2:0][DW-1:0]  win_o,
  output logic                     vsync_o,
  output logic                     href_o,
  output logic                     clken_o
);

  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int LW = $clog2(IMG_VDISP + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_HDISP - 1);

  logic [AW-1:0]            addr_q, addr_d;
  logic [LW-1:0]            line_q, line_d;
  logic                     href_prev_q;
  logic [LAT_B-1:0]         vs_q, hr_q, ck_q;
  pix_t                     lb1 [IMG_HDISP];
  pix_t                     lb2 [IMG_HDISP];
  pix_t                     rd1, rd2;
  logic [2:0][DW-1:0]       col_q, col_d;
  logic [2:0][2:0][DW-1:0]  win_q, win_d;

  // Address walk, line counting, masked column capture, window shift.
  always_comb begin
    addr_d = addr_q;
    if (!href_i) begin
      addr_d = '0;
    end else if (clken_i) begin
      addr_d = (addr_q >= ADDR_LAST) ? '0 : addr_q + AW'(1);
    end

    line_d = line_q;
    if (!vsync_i) begin
      line_d = '0;
    end else if (href_prev_q && !href_i && line_q != LW'(2)) begin
      line_d = line_q + LW'(1);
    end

    rd1 = lb1[addr_q];
    rd2 = lb2[addr_q];

    col_d = col_q;
    if (clken_i) begin
      col_d[2] = y_i;
      col_d[1] = (line_q == '0) ? '0 : rd1;
      col_d[0] = (line_q < LW'(2)) ? '0 : rd2;
    end

    win_d = win_q;
    if (!hr_q[0]) begin
      win_d = '0;
    end else if (ck_q[0]) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r] = {col_q[r], win_q[r][2], win_q[r][1]};
      end
    end
  end

  // Line buffers: newest line into lb1, previous line cascades to lb2.
  always_ff @(posedge clk) begin
    if (clken_i) begin
      lb1[addr_q] <= y_i;
      lb2[addr_q] <= rd1;
    end
  end

  // Control, column and window state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      line_q      <= '0;
      href_prev_q <= 1'b0;
      vs_q        <= '0;
      hr_q        <= '0;
      ck_q        <= '0;
      col_q       <= '0;
      win_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      line_q      <= line_d;
      href_prev_q <= href_i;
      vs_q        <= {vs_q[LAT_B-2:0], vsync_i};
      hr_q        <= {hr_q[LAT_B-2:0], href_i};
      ck_q        <= {ck_q[LAT_B-2:0], clken_i};
      col_q       <= col_d;
      win_q       <= win_d;
    end
  end

  assign win_o   = win_q;
  assign vsync_o = vs_q[LAT_B-1];
  assign href_o  = hr_q[LAT_B-1];
  assign clken_o = ck_q[LAT_B-1];

endmodule

// File: rtl/video_median_processor.sv
// RGB565 -> luma -> 3x3 median filter, 8 clk end to end.
// Sync signals travel alongside the data through every stage.
module video_median_processor
  import video_median_processor_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [15:0]   per_img_Y,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [DW-1:0] post_img_Y
);

  localparam int C_SYNC = LAT_TOTAL - LAT_A - LAT_B;

  logic [LAT_A-1:0]         vs_a_q, hr_a_q, ck_a_q;
  pix_t                     r8, g8, b8;
  logic [ACC_W-1:0]         pr_q, pg_q, pb_q;
  logic [ACC_W-1:0]         pr_d, pg_d, pb_d;
  logic [ACC_W-1:0]         sum_q, sum_d;
  pix_t                     y_q, y_d;

  logic [2:0][2:0][DW-1:0]  win;
  logic                     m_vs, m_hr, m_ck;

  trio_t [2:0]              row_q, row_d;
  pix_t                     mom_q, mom_d;
  pix_t                     mid_q, mid_d;
  pix_t                     mnx_q, mnx_d;
  pix_t                     out_q, out_d;
  logic [C_SYNC-1:0]        vs_c_q, hr_c_q, ck_c_q;

  // Colour expansion and weighted luma sum.
  always_comb begin
    r8    = {per_img_Y[15:11], per_img_Y[15:13]};
    g8    = {per_img_Y[10:5],  per_img_Y[10:9]};
    b8    = {per_img_Y[4:0],   per_img_Y[4:2]};
    pr_d  = ACC_W'(r8) * ACC_W'(COEF_R);
    pg_d  = ACC_W'(g8) * ACC_W'(COEF_G);
    pb_d  = ACC_W'(b8) * ACC_W'(COEF_B);
    sum_d = pr_q + pg_q + pb_q;
    y_d   = DW'(sum_q >> Y_SHIFT);
  end

  // Luma pipeline plus its sync delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_a_q <= '0;
      hr_a_q <= '0;
      ck_a_q <= '0;
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      sum_q  <= '0;
      y_q    <= '0;
    end else begin
      vs_a_q <= {vs_a_q[LAT_A-2:0], per_frame_vsync};
      hr_a_q <= {hr_a_q[LAT_A-2:0], per_frame_href};
      ck_a_q <= {ck_a_q[LAT_A-2:0], per_frame_clken};
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      sum_q  <= sum_d;
      y_q    <= y_d;
    end
  end

  video_median_processor_matrix_3x3_gen #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_matrix (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vs_a_q[LAT_A-1]),
    .href_i  (hr_a_q[LAT_A-1]),
    .clken_i (ck_a_q[LAT_A-1]),
    .y_i     (y_q),
    .win_o   (win),
    .vsync_o (m_vs),
    .href_o  (m_hr),
    .clken_o (m_ck)
  );

  // Row sort, cross-row reduction, final median with idle blanking.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_d[r] = sort3(win[r][0], win[r][1], win[r][2]);
    end
    mom_d = max3(row_q[0].mn, row_q[1].mn, row_q[2].mn);
    mid_d = med3(row_q[0].md, row_q[1].md, row_q[2].md);
    mnx_d = min3(row_q[0].mx, row_q[1].mx, row_q[2].mx);
    out_d = ck_c_q[LAT_C-2] ? med3(mom_q, mid_q, mnx_q) : '0;
  end

  // Median pipeline plus its sync delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      mom_q  <= '0;
      mid_q  <= '0;
      mnx_q  <= '0;
      out_q  <= '0;
      vs_c_q <= '0;
      hr_c_q <= '0;
      ck_c_q <= '0;
    end else begin
      row_q  <= row_d;
      mom_q  <= mom_d;
      mid_q  <= mid_d;
      mnx_q  <= mnx_d;
      out_q  <= out_d;
      vs_c_q <= {vs_c_q[C_SYNC-2:0], m_vs};
      hr_c_q <= {hr_c_q[C_SYNC-2:0], m_hr};
      ck_c_q <= {ck_c_q[C_SYNC-2:0], m_ck};
    end
  end

  assign post_frame_vsync = vs_c_q[C_SYNC-1];
  assign post_frame_href  = hr_c_q[C_SYNC-1];
  assign post_frame_clken = ck_c_q[C_SYNC-1];
  assign post_img_Y       = out_q;

endmodule

// File: tb/tb_video_median_processor.sv
// Bench for video_median_processor: directed and random frames
// against a window-level median model.
module tb_video_median_processor;

  localparam int W = 32;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [15:0] per_img_Y = '0;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [7:0]  post_img_Y;

  always #5 clk = ~clk;

  video_median_processor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Y       (post_img_Y)
  );

  typedef struct {
    logic vs;
    logic hr;
    logic ck;
    int   ln;
    int   cl;
  } h_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] px [L][W];
  int          fr [L][W];
  int          capY [L][W];
  int          lcnt [L];
  int          fcnt;
  int          cap_q [$];
  int          pad_ref [$];
  h_t          hq [$];
  bit          ramp_on = 1'b0;

  function automatic int luma(logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  function automatic int pel(int n, int x);
    if (n < 0 || x < 0) return 0;
    return fr[n][x];
  endfunction

  function automatic int median_model(int n, int x);
    int mins [$];
    int mids [$];
    int maxs [$];
    int fin [$];
    for (int r = n - 2; r <= n; r++) begin
      int q [$];
      q = '{pel(r, x - 2), pel(r, x - 1), pel(r, x)};
      q.sort();
      mins.push_back(q[0]);
      mids.push_back(q[1]);
      maxs.push_back(q[2]);
    end
    mins.sort();
    mids.sort();
    maxs.sort();
    fin = '{mins[2], mids[1], maxs[0]};
    fin.sort();
    return fin[1];
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic prime_hist();
    h_t z;
    z = '{vs: 1'b0, hr: 1'b0, ck: 1'b0, ln: -1, cl: -1};
    hq.delete();
    repeat (7) hq.push_back(z);
  endtask

  // Drive one cycle, then check the outputs against the input 8 clk back.
  task automatic step(input logic vs, input logic hr, input logic ck,
                      input logic [15:0] p, input int ln, input int cl);
    h_t h;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_Y       = p;
    @(negedge clk);
    h = '{vs: vs, hr: hr, ck: ck, ln: ln, cl: cl};
    hq.push_back(h);
    if (hq.size() > 7) begin
      h = hq.pop_front();
      cmp("vsync_dly", 32'(post_frame_vsync), 32'(h.vs));
      cmp("href_dly", 32'(post_frame_href), 32'(h.hr));
      cmp("clken_dly", 32'(post_frame_clken), 32'(h.ck));
      if (h.ck) begin
        cmp($sformatf("pix_l%0d_c%0d", h.ln, h.cl),
            32'(post_img_Y), 32'(median_model(h.ln, h.cl)));
        if (ramp_on && h.ln >= 2 && h.cl >= 2)
          cmp($sformatf("ramp_l%0d_c%0d", h.ln, h.cl),
              32'(post_img_Y), 32'(fr[h.ln][h.cl - 1]));
      end else begin
        cmp("idle_y", 32'(post_img_Y), 32'd0);
      end
      if (post_frame_clken) begin
        cap_q.push_back(int'(post_img_Y));
        fcnt++;
        if (h.ln >= 0 && h.ln < L && h.cl >= 0 && h.cl < W) begin
          capY[h.ln][h.cl] = int'(post_img_Y);
          lcnt[h.ln]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_vsync", 32'(post_frame_vsync), 32'd0);
    cmp("rst_href", 32'(post_frame_href), 32'd0);
    cmp("rst_clken", 32'(post_frame_clken), 32'd0);
    cmp("rst_y", 32'(post_img_Y), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prime_hist();
  endtask

  // mode: 0 dense clken, 1 every 2nd clk, 2 random; rst_line >= 0 aborts.
  task automatic run_frame(input int mode, input int rst_line);
    int x, t;
    bit ck;
    cap_q.delete();
    fcnt = 0;
    for (int n = 0; n < L; n++) begin
      lcnt[n] = 0;
      for (int c = 0; c < W; c++) begin
        capY[n][c] = -1;
        fr[n][c]   = luma(px[n][c]);
      end
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'($urandom), -1, -1);
    for (int n = 0; n < L; n++) begin
      x = 0;
      t = 0;
      while (x < W) begin
        if (mode == 0) ck = 1'b1;
        else if (mode == 1) ck = (t % 2) == 1;
        else ck = 1'($urandom_range(0, 1));
        if (ck) begin
          if (n == rst_line && x == 5) begin
            do_reset();
            return;
          end
          step(1'b1, 1'b1, 1'b1, px[n][x], n, x);
          x++;
        end else begin
          step(1'b1, 1'b1, 1'b0, 16'($urandom), -1, -1);
        end
        t++;
      end
      repeat (4) step(1'b1, 1'b0, 1'b0, 16'($urandom), -1, -1);
    end
    repeat (12) step(1'b0, 1'b0, 1'b0, 16'($urandom), -1, -1);
    for (int n = 0; n < L; n++)
      cmp($sformatf("line%0d_pulses", n), 32'(lcnt[n]), 32'(W));
    cmp("frame_pulses", 32'(fcnt), 32'(W * L));
  endtask

  task automatic fill(input logic [15:0] v);
    for (int n = 0; n < L; n++)
      for (int c = 0; c < W; c++)
        px[n][c] = v;
  endtask

  logic [15:0] cpix [5];
  int          cexp [5];

  initial begin
    cpix = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
    cexp = '{76, 149, 28, 255, 0};

    #12;
    cmp("reset_vsync", 32'(post_frame_vsync), 32'd0);
    cmp("reset_href", 32'(post_frame_href), 32'd0);
    cmp("reset_clken", 32'(post_frame_clken), 32'd0);
    cmp("reset_y", 32'(post_img_Y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prime_hist();

    for (int i = 0; i < 5; i++) begin
      fill(cpix[i]);
      run_frame(0, -1);
      cmp($sformatf("colour_%h", cpix[i]), 32'(capY[2][2]), 32'(cexp[i]));
      cmp($sformatf("colour_%h_edge", cpix[i]), 32'(capY[3][31]),
          32'(cexp[i]));
    end

    fill(16'hFFFF);
    run_frame(0, -1);
    pad_ref = cap_q;
    cmp("pad_l0", 32'(capY[0][7]), 32'd0);
    cmp("pad_l1_c0", 32'(capY[1][0]), 32'd0);
    cmp("pad_l1_c5", 32'(capY[1][5]), 32'd255);
    cmp("pad_l2_c0", 32'(capY[2][0]), 32'd0);
    cmp("pad_l2_c1", 32'(capY[2][1]), 32'd255);
    cmp("pad_l3_c1", 32'(capY[3][1]), 32'd255);

    fill(16'h0000);
    px[2][10] = 16'hFFFF;
    run_frame(0, -1);
    cmp("impulse_l2_c10", 32'(capY[2][10]), 32'd0);
    cmp("impulse_l2_c12", 32'(capY[2][12]), 32'd0);

    for (int n = 0; n < L; n++)
      for (int c = 0; c < W; c++)
        px[n][c] = 16'($urandom);
    run_frame(1, -1);

    for (int n = 0; n < L; n++)
      for (int c = 0; c < W; c++)
        px[n][c] = {5'(c), 6'(2 * c), 5'(c)};
    ramp_on = 1'b1;
    run_frame(1, -1);
    ramp_on = 1'b0;

    repeat (3) begin
      for (int n = 0; n < L; n++)
        for (int c = 0; c < W; c++)
          px[n][c] = 16'($urandom);
      run_frame(2, -1);
    end

    fill(16'hFFFF);
    run_frame(0, 1);
    repeat (12) step(1'b0, 1'b0, 1'b0, 16'h0000, -1, -1);
    run_frame(1, -1);
    cmp("rst_frame_size", 32'(cap_q.size()), 32'(pad_ref.size()));
    for (int i = 0; i < cap_q.size() && i < pad_ref.size(); i++)
      cmp($sformatf("rst_frame_%0d", i), 32'(cap_q[i]), 32'(pad_ref[i]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
